// File: rtl/dram_arbiter.sv
`default_nettype none
// ==========================================================================
// dram_arbiter : two-master single-port data RAM arbiter with alignment check
// Revision     : 1.0
// ==========================================================================
module dram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [2:0]        m0_sel_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m0_lock_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [2:0]        m1_sel_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [2:0]        ram_sel_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic              rr_last;
    logic              lock_vld;
    logic              lock_id;
    logic [CNT_W-1:0]  starve0;
    logic [CNT_W-1:0]  starve1;
    logic [CNT_W-1:0]  starve0_nxt;
    logic [CNT_W-1:0]  starve1_nxt;

    logic              grant;
    logic              win;
    logic              tie_win;
    logic              starving0;
    logic              starving1;
    logic              lock_hit;

    logic              sel_we;
    logic              sel_lock;
    logic              misaligned;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_sel;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] hold_addr;
    logic [2:0]        hold_sel;
    logic [DATA_W-1:0] hold_wdata;

    assign starving0 = m0_req_i && (starve0 == STARVE_LIM);
    assign starving1 = m1_req_i && (starve1 == STARVE_LIM);
    assign lock_hit  = lock_vld && (lock_id ? m1_req_i : m0_req_i);
    assign tie_win   = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last;

    // Starvation outranks an existing lock so a locking master cannot hog the RAM.
    always_comb begin
        grant = rst && (m0_req_i || m1_req_i);
        win   = 1'b0;
        if (starving0 && starving1)
            win = tie_win;
        else if (starving0)
            win = 1'b0;
        else if (starving1)
            win = 1'b1;
        else if (lock_hit)
            win = lock_id;
        else if (m0_req_i && m1_req_i)
            win = tie_win;
        else
            win = m1_req_i;
    end

    assign sel_we    = win ? m1_we_i    : m0_we_i;
    assign sel_lock  = win ? m1_lock_i  : m0_lock_i;
    assign sel_addr  = win ? m1_addr_i  : m0_addr_i;
    assign sel_sel   = win ? m1_sel_i   : m0_sel_i;
    assign sel_wdata = win ? m1_wdata_i : m0_wdata_i;

    assign misaligned = (sel_sel == 3'b001) ? sel_addr[0]
                      : (sel_sel != 3'b000) && (sel_addr[1:0] != 2'b00);

    assign m0_gnt_o    = grant && !win;
    assign m1_gnt_o    = grant && win;
    assign ram_ce_o    = grant && !misaligned && !sel_we;
    assign ram_we_o    = grant && !misaligned && sel_we;
    assign ram_addr_o  = grant ? sel_addr  : hold_addr;
    assign ram_sel_o   = grant ? sel_sel   : hold_sel;
    assign ram_wdata_o = grant ? sel_wdata : hold_wdata;

    assign starve0_nxt = (!m0_req_i || m0_gnt_o) ? '0
                       : (starve0 == STARVE_LIM) ? starve0 : starve0 + 1'b1;
    assign starve1_nxt = (!m1_req_i || m1_gnt_o) ? '0
                       : (starve1 == STARVE_LIM) ? starve1 : starve1 + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last     <= 1'b1;
            lock_vld    <= 1'b0;
            lock_id     <= 1'b0;
            starve0     <= '0;
            starve1     <= '0;
            hold_addr   <= '0;
            hold_sel    <= '0;
            hold_wdata  <= '0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_err_o    <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rdata_o  <= '0;
        end else begin
            starve0     <= starve0_nxt;
            starve1     <= starve1_nxt;
            m0_rvalid_o <= m0_gnt_o;
            m1_rvalid_o <= m1_gnt_o;
            m0_err_o    <= m0_gnt_o && misaligned;
            m1_err_o    <= m1_gnt_o && misaligned;
            if (grant) begin
                rr_last    <= win;
                lock_vld   <= sel_lock;
                lock_id    <= win;
                hold_addr  <= sel_addr;
                hold_sel   <= sel_sel;
                hold_wdata <= sel_wdata;
            end
            // A misaligned access never touched the RAM, so its response carries zero.
            if (m0_gnt_o)
                m0_rdata_o <= misaligned ? '0 : ram_rdata_i;
            if (m1_gnt_o)
                m1_rdata_o <= misaligned ? '0 : ram_rdata_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// tb_dram_arbiter: directed and random checks of a round-robin instance (k=0) and a
// fixed-priority instance (k=1) against a transaction-level arbitration model.
module tb_dram_arbiter;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_sel, m1_sel;

    logic        a_g0, a_g1, a_rv0, a_rv1, a_e0, a_e1, a_ce, a_we;
    logic [31:0] a_rd0, a_rd1, a_addr, a_wd, a_rram;
    logic [2:0]  a_sel;
    logic        b_g0, b_g1, b_rv0, b_rv1, b_e0, b_e1, b_ce, b_we;
    logic [31:0] b_rd0, b_rd1, b_addr, b_wd, b_rram;
    logic [2:0]  b_sel;

    logic [31:0] mem [2][64];
    int checks = 0;
    int errors = 0;

    // snapshots of DUT outputs and model expectations, indexed by instance
    logic [1:0]  s_gnt [2], s_rv [2], s_err [2], e_gnt [2], e_rv [2], e_err [2];
    logic        s_ce [2], s_we [2], e_ce [2], e_we [2];
    logic [31:0] s_addr [2], s_wd [2], e_addr [2], e_wd [2];
    logic [2:0]  s_sel [2], e_sel [2];
    logic [31:0] s_rd [2][2], e_rd [2][2];
    bit          e_rdchk [2][2];

    // model state
    int          rr [2], lk [2], st [2][2];
    bit          p_rv [2][2], p_err [2][2], p_rdchk [2][2];
    logic [31:0] p_rd [2][2];
    logic [31:0] h_addr [2], h_wd [2];
    logic [2:0]  h_sel [2];

    always #5 clk = ~clk;

    assign a_rram = mem[0][a_addr[7:2]];
    assign b_rram = mem[1][b_addr[7:2]];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) begin
                mem[0][i] <= $urandom;
                mem[1][i] <= $urandom;
            end
        end else begin
            if (a_we) mem[0][a_addr[7:2]] <= a_wd;
            if (b_we) mem[1][b_addr[7:2]] <= b_wd;
        end
    end

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
        .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock), .m0_gnt_o(a_g0), .m0_rvalid_o(a_rv0),
        .m0_rdata_o(a_rd0), .m0_err_o(a_e0),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
        .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock), .m1_gnt_o(a_g1), .m1_rvalid_o(a_rv1),
        .m1_rdata_o(a_rd1), .m1_err_o(a_e1),
        .ram_ce_o(a_ce), .ram_we_o(a_we), .ram_addr_o(a_addr), .ram_sel_o(a_sel),
        .ram_wdata_o(a_wd), .ram_rdata_i(a_rram)
    );

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
        .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock), .m0_gnt_o(b_g0), .m0_rvalid_o(b_rv0),
        .m0_rdata_o(b_rd0), .m0_err_o(b_e0),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
        .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock), .m1_gnt_o(b_g1), .m1_rvalid_o(b_rv1),
        .m1_rdata_o(b_rd1), .m1_err_o(b_e1),
        .ram_ce_o(b_ce), .ram_we_o(b_we), .ram_addr_o(b_addr), .ram_sel_o(b_sel),
        .ram_wdata_o(b_wd), .ram_rdata_i(b_rram)
    );

    // Expected behaviour of instance k for the current cycle, then advance its state.
    task automatic model_step(input int k);
        bit          req [2], we [2], lck [2];
        bit [31:0]   ad [2], wd [2];
        bit [2:0]    sl [2];
        int          w, tie;
        bit          mis, stv0, stv1;
        req[0] = m0_req; we[0] = m0_we; lck[0] = m0_lock; ad[0] = m0_addr; wd[0] = m0_wdata; sl[0] = m0_sel;
        req[1] = m1_req; we[1] = m1_we; lck[1] = m1_lock; ad[1] = m1_addr; wd[1] = m1_wdata; sl[1] = m1_sel;
        e_rv[k]  = {p_rv[k][1], p_rv[k][0]};
        e_err[k] = {p_err[k][1], p_err[k][0]};
        for (int n = 0; n < 2; n++) begin
            e_rd[k][n]    = p_rd[k][n];
            e_rdchk[k][n] = p_rdchk[k][n];
            p_rv[k][n] = 0; p_err[k][n] = 0; p_rdchk[k][n] = 0;
        end
        if (!rst) begin
            e_gnt[k] = 0; e_ce[k] = 0; e_we[k] = 0; e_addr[k] = 0; e_sel[k] = 0; e_wd[k] = 0;
            e_rv[k] = 0; e_err[k] = 0;
            rr[k] = 1; lk[k] = -1; h_addr[k] = 0; h_sel[k] = 0; h_wd[k] = 0;
            for (int n = 0; n < 2; n++) begin
                e_rd[k][n] = 0; e_rdchk[k][n] = 1; st[k][n] = 0; p_rd[k][n] = 0;
            end
            return;
        end
        tie  = (k == 1) ? 0 : 1 - rr[k];
        stv0 = req[0] && st[k][0] == SMAX;
        stv1 = req[1] && st[k][1] == SMAX;
        if (stv0 && stv1) w = tie;
        else if (stv0) w = 0;
        else if (stv1) w = 1;
        else if (lk[k] >= 0 && req[lk[k]]) w = lk[k];
        else if (req[0] && req[1]) w = tie;
        else if (req[0]) w = 0;
        else if (req[1]) w = 1;
        else w = -1;
        for (int n = 0; n < 2; n++) begin
            if (!req[n] || w == n) st[k][n] = 0;
            else if (st[k][n] < SMAX) st[k][n] = st[k][n] + 1;
        end
        if (w < 0) begin
            e_gnt[k] = 0; e_ce[k] = 0; e_we[k] = 0;
            e_addr[k] = h_addr[k]; e_sel[k] = h_sel[k]; e_wd[k] = h_wd[k];
        end else begin
            mis = (sl[w] == 1 && ad[w] % 2 != 0) || (sl[w] > 1 && ad[w] % 4 != 0);
            e_gnt[k] = (w == 0) ? 2'b01 : 2'b10;
            e_ce[k]  = !mis && !we[w];
            e_we[k]  = !mis && we[w];
            e_addr[k] = ad[w]; e_sel[k] = sl[w]; e_wd[k] = wd[w];
            h_addr[k] = ad[w]; h_sel[k] = sl[w]; h_wd[k] = wd[w];
            p_rv[k][w]    = 1;
            p_err[k][w]   = mis;
            p_rdchk[k][w] = mis || !we[w];
            p_rd[k][w]    = mis ? 32'h0 : mem[k][ad[w][7:2]];
            rr[k] = w;
            lk[k] = lck[w] ? w : -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_gnt[0] = {a_g1, a_g0}; s_rv[0] = {a_rv1, a_rv0}; s_err[0] = {a_e1, a_e0};
        s_ce[0] = a_ce; s_we[0] = a_we; s_addr[0] = a_addr; s_sel[0] = a_sel; s_wd[0] = a_wd;
        s_rd[0][0] = a_rd0; s_rd[0][1] = a_rd1;
        s_gnt[1] = {b_g1, b_g0}; s_rv[1] = {b_rv1, b_rv0}; s_err[1] = {b_e1, b_e0};
        s_ce[1] = b_ce; s_we[1] = b_we; s_addr[1] = b_addr; s_sel[1] = b_sel; s_wd[1] = b_wd;
        s_rd[1][0] = b_rd0; s_rd[1][1] = b_rd1;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_sel = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_sel = 0; m1_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 0; fill = 1; drive_idle();
        m0_req = 1; m1_req = 1; m1_we = 1; m0_addr = 32'h8; m1_addr = 32'hC;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({s_gnt[k], s_ce[k], s_we[k], s_rv[k], s_err[k]} !== 8'h0) begin
                errors++; $display("FAIL reset_ctrl k=%0d got %b exp 0", k, {s_gnt[k], s_ce[k], s_we[k], s_rv[k], s_err[k]});
            end
            checks++;
            if ({s_addr[k], s_sel[k], s_wd[k], s_rd[k][0], s_rd[k][1]} !== 131'h0) begin
                errors++; $display("FAIL reset_data k=%0d addr %h sel %h wd %h rd0 %h rd1 %h exp 0", k, s_addr[k], s_sel[k], s_wd[k], s_rd[k][0], s_rd[k][1]);
            end
        end
        fill = 0; rst = 1; drive_idle();
        tick();
    endtask

    task automatic test_single_read();
        logic [31:0] word [2];
        word[0] = mem[0][4]; word[1] = mem[1][4];
        drive_idle(); m0_req = 1; m0_addr = 32'h10; m0_sel = 3'b010;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({s_gnt[k], s_ce[k], s_we[k]} !== 4'b0110) begin
                errors++; $display("FAIL single_read_gnt k=%0d got gnt %b ce %b we %b exp 01 1 0", k, s_gnt[k], s_ce[k], s_we[k]);
            end
            checks++;
            if (s_addr[k] !== 32'h10) begin
                errors++; $display("FAIL single_read_addr k=%0d got %h exp 10", k, s_addr[k]);
            end
        end
        drive_idle();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (s_rv[k] !== 2'b01 || s_rd[k][0] !== word[k]) begin
                errors++; $display("FAIL single_read_resp k=%0d got rv %b rd %h exp 01 %h", k, s_rv[k], s_rd[k][0], word[k]);
            end
        end
    endtask

    task automatic test_alternate();
        logic [1:0] prev = 2'b00;
        drive_idle(); m0_req = 1; m1_req = 1; m0_sel = 3'b010; m1_sel = 3'b010;
        for (int i = 0; i < 8; i++) begin
            m0_addr = 32'($urandom_range(0, 63) * 4);
            m1_addr = 32'($urandom_range(0, 63) * 4);
            tick();
            checks++;
            if (s_gnt[0] !== e_gnt[0] || (i > 0 && s_gnt[0] === prev) || s_gnt[0] === 2'b00) begin
                errors++; $display("FAIL alternate_gnt cyc=%0d got %b exp %b prev %b", i, s_gnt[0], e_gnt[0], prev);
            end
            checks++;
            if (s_rv[0] !== prev) begin
                errors++; $display("FAIL alternate_rvalid cyc=%0d got %b exp %b", i, s_rv[0], prev);
            end
            prev = s_gnt[0];
        end
        drive_idle();
        tick();
    endtask

    task automatic test_fixed_starve();
        drive_idle(); m0_req = 1; m1_req = 1; m0_sel = 3'b010; m1_sel = 3'b010;
        m0_addr = 32'h20; m1_addr = 32'h24;
        for (int i = 0; i < 10; i++) begin
            logic [1:0] want;
            want = (i == 4 || i == 9) ? 2'b10 : 2'b01;
            tick();
            checks++;
            if (s_gnt[1] !== want || s_gnt[1] !== e_gnt[1]) begin
                errors++; $display("FAIL fixed_starve cyc=%0d got %b exp %b", i, s_gnt[1], want);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_lock();
        drive_idle(); m0_req = 1; m0_sel = 3'b010; m0_addr = 32'h30;
        tick();
        m1_req = 1; m1_lock = 1; m1_sel = 3'b010; m1_addr = 32'h34;
        for (int i = 0; i < 10; i++) begin
            logic [1:0] want;
            want = (i == 4 || i == 9) ? 2'b01 : 2'b10;
            tick();
            checks++;
            if (s_gnt[0] !== want || s_gnt[0] !== e_gnt[0]) begin
                errors++; $display("FAIL lock_starve cyc=%0d got %b exp %b", i, s_gnt[0], want);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_misaligned();
        logic [31:0] old [2];
        old[0] = mem[0][8]; old[1] = mem[1][8];
        drive_idle(); m0_req = 1; m0_we = 1; m0_addr = 32'h22; m0_sel = 3'b010; m0_wdata = $urandom;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({s_gnt[k], s_ce[k], s_we[k]} !== 4'b0100) begin
                errors++; $display("FAIL misaligned_wr k=%0d got gnt %b ce %b we %b exp 01 0 0", k, s_gnt[k], s_ce[k], s_we[k]);
            end
        end
        drive_idle(); m1_req = 1; m1_addr = 32'h13; m1_sel = 3'b001;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (s_rv[k] !== 2'b01 || s_err[k] !== 2'b01 || s_rd[k][0] !== 32'h0) begin
                errors++; $display("FAIL misaligned_wr_resp k=%0d got rv %b err %b rd %h exp 01 01 0", k, s_rv[k], s_err[k], s_rd[k][0]);
            end
            checks++;
            if (mem[k][8] !== old[k]) begin
                errors++; $display("FAIL misaligned_ram k=%0d got %h exp %h", k, mem[k][8], old[k]);
            end
            checks++;
            if ({s_gnt[k], s_ce[k], s_we[k]} !== 4'b1000) begin
                errors++; $display("FAIL misaligned_rd k=%0d got gnt %b ce %b we %b exp 10 0 0", k, s_gnt[k], s_ce[k], s_we[k]);
            end
        end
        drive_idle();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (s_rv[k] !== 2'b10 || s_err[k] !== 2'b10 || s_rd[k][1] !== 32'h0) begin
                errors++; $display("FAIL misaligned_rd_resp k=%0d got rv %b err %b rd %h exp 10 10 0", k, s_rv[k], s_err[k], s_rd[k][1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_idle(); m1_req = 1; m1_addr = 32'h40; m1_sel = 3'b010;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (s_gnt[k] !== 2'b10) begin
                errors++; $display("FAIL rstmid_gnt k=%0d got %b exp 10", k, s_gnt[k]);
            end
        end
        drive_idle(); rst = 0;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({s_gnt[k], s_ce[k], s_we[k], s_rv[k], s_err[k], s_addr[k], s_rd[k][1]} !== 72'h0) begin
                errors++; $display("FAIL rstmid_outputs k=%0d got gnt %b rv %b err %b addr %h rd1 %h exp 0", k, s_gnt[k], s_rv[k], s_err[k], s_addr[k], s_rd[k][1]);
            end
        end
        rst = 1; m0_req = 1; m1_req = 1; m0_addr = 32'h44; m1_addr = 32'h48; m0_sel = 3'b010; m1_sel = 3'b010;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (s_gnt[k] !== 2'b01) begin
                errors++; $display("FAIL rstmid_first_tie k=%0d got %b exp 01", k, s_gnt[k]);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic rand_master(output logic req, output logic we, output logic lock,
                               output logic [31:0] addr, output logic [31:0] wdata,
                               output logic [2:0] sel);
        req   = ($urandom_range(0, 3) != 0);
        we    = $urandom_range(0, 1) == 1;
        lock  = ($urandom_range(0, 3) == 0);
        addr  = 32'($urandom_range(0, 63) * 4 + (($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0));
        wdata = $urandom;
        sel   = 3'($urandom_range(0, 3));
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_master(m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_sel);
            rand_master(m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_sel);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (s_gnt[k] !== e_gnt[k] || s_ce[k] !== e_ce[k] || s_we[k] !== e_we[k]) begin
                    errors++; $display("FAIL rand_grant cyc=%0d k=%0d got gnt %b ce %b we %b exp %b %b %b", i, k, s_gnt[k], s_ce[k], s_we[k], e_gnt[k], e_ce[k], e_we[k]);
                end
                checks++;
                if (s_addr[k] !== e_addr[k] || s_sel[k] !== e_sel[k] || s_wd[k] !== e_wd[k]) begin
                    errors++; $display("FAIL rand_bus cyc=%0d k=%0d got %h/%h/%h exp %h/%h/%h", i, k, s_addr[k], s_sel[k], s_wd[k], e_addr[k], e_sel[k], e_wd[k]);
                end
                checks++;
                if (s_rv[k] !== e_rv[k] || s_err[k] !== e_err[k]) begin
                    errors++; $display("FAIL rand_resp cyc=%0d k=%0d got rv %b err %b exp %b %b", i, k, s_rv[k], s_err[k], e_rv[k], e_err[k]);
                end
                for (int n = 0; n < 2; n++) begin
                    if (e_rv[k][n] && e_rdchk[k][n]) begin
                        checks++;
                        if (s_rd[k][n] !== e_rd[k][n]) begin
                            errors++; $display("FAIL rand_rdata cyc=%0d k=%0d m=%0d got %h exp %h", i, k, n, s_rd[k][n], e_rd[k][n]);
                        end
                    end
                end
            end
        end
        drive_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_fixed_starve();
        test_lock();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
